uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serialising transmitter stage that drains the UART transmit FIFO and drives the serial TXD line. It pops one byte at a time from the FIFO and emits an asynchronous frame: start bit, 5–8 data bits LSB first, optional parity, and 1/1.5/2 stop bits. Bit timing comes from a 16x oversampling baud prescaler. Sits between the TX FIFO (fifoRe/fifoEmpty/dataOut) and the pad.

## Interface
- No parameters; frame format and baud rate are run-time inputs.
- clock  in  1  system clock
- reset  in  1  synchronous, active-low (0 = reset)
- fifoEmpty  in  1  TX FIFO empty flag
- fifoData  in  8  TX FIFO head byte; valid combinationally whenever fifoEmpty=0
- fifoRe  out  1  one-cycle pop strobe to TX FIFO
- baudDivisor  in  16  clock cycles per 16x tick; 0 = transmitter halted
- wordLength  in  2  data bits = 5 + wordLength
- stopBits  in  1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when wordLength=0)
- parityEnable, parityEven, stickParity  in  1 each  parity control
- breakCtrl  in  1  force TXD low
- txd  out  1  serial output, idle high
- busy  out  1  frame in progress
- txEmpty  out  1  FIFO empty and no frame in progress

## Operation
- Reset values: txd=1, fifoRe=0, busy=0, txEmpty=1; FSM IDLE; prescaler and counters 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if fifoEmpty=0 and baudDivisor≠0, assert fifoRe for exactly one cycle, latch fifoData into shift register, clear prescaler, go to START.
- Each bit lasts 16 ticks; stop phase lasts 16, 24 (1.5) or 32 ticks.
- START: txd=0. DATA: txd=shift[0], shift right each bit; after 5+wordLength bits go to PARITY if enabled, else STOP.
- Parity: even = XOR of data bits; odd = its inverse; stickParity=1 sends !parityEven (1 for odd, 0 for even).
- STOP: txd=1. At end: if fifoEmpty=0 pop immediately and go to START (no idle gap); else go to IDLE.
- Unused high data bits (wordLength<3) are not sent.
- breakCtrl=1: txd=0 regardless of state; FSM keeps running; frames keep draining.
- Format inputs are sampled at each bit boundary; changing them mid-frame is undefined but must not hang the FSM.
- baudDivisor=0 mid-frame: prescaler holds, frame freezes, txd holds its level; resumes when nonzero.
- Reset mid-frame: immediate return to reset values; partially sent byte is lost; no pop.
- fifoRe is never asserted while fifoEmpty=1.

## Timing
- Pop in cycle N; txd falls in cycle N+1 (registered output).
- Bit period = 16·baudDivisor cycles; a frame of 8N1 at divisor D = 160·D cycles from txd fall to the end of the stop bit.
- Prescaler tick when its count reaches baudDivisor−1; it reloads to 0; a divisor change takes effect at the next reload.
- Back-to-back frames: next fifoRe coincides with the last cycle of the stop bit; the next start bit begins the following cycle.
- busy is high from cycle N+1 through the last stop cycle. txEmpty = fifoEmpty & ~busy & ~fifoRe.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity logic present; parity inputs behave as specified.
- Undefined: PARITY state removed; parityEnable/parityEven/stickParity ports remain but are ignored; DATA goes directly to STOP.

## Structure
- Shared package uart_pkg: FSM state encoding, TICKS_PER_BIT=16, TICKS_STOP_1P5=24, TICKS_STOP_2=32, word-length encoding.
- One sub-module: uart_baud_gen (16-bit prescaler with synchronous clear and divisor-0 hold, outputs tick16).

## Test plan
- Divisor=1, 8N1, FIFO holds 0x55 → one fifoRe pulse; txd: 0 for 16 cycles, then 1,0,1,0,1,0,1,0 of 16 cycles each, then 1; busy low after 160 cycles; txEmpty=1.
- Divisor=2, 7E1, bytes 0x41 then 0x7F queued → back-to-back frames, no idle gap; parity bits 0 then 1; each frame 320 cycles.
- Divisor=1, 5 bits, stopBits=1, 0x1F → stop phase 24 cycles; upper data bits ignored.
- breakCtrl=1 during a frame of 0xFF → txd=0 throughout; FIFO still drained; txd=1 on release in IDLE.
- Reset low in the middle of DATA → next cycle txd=1, busy=0, fifoRe=0; after release the next queued byte is sent cleanly.
- baudDivisor=0 with FIFO nonempty → no fifoRe, txd=1; set to 3 → frame starts, bit period 48 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter: FSM states, tick counts and word-length codes.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int TICKS_PER_BIT  = 16;
    localparam int TICKS_STOP_1P5 = 24;
    localparam int TICKS_STOP_2   = 32;

    localparam logic [1:0] WL_5 = 2'd0;
    localparam logic [1:0] WL_6 = 2'd1;
    localparam logic [1:0] WL_7 = 2'd2;
    localparam logic [1:0] WL_8 = 2'd3;

    function automatic logic [2:0] lastDataBit(input logic [1:0] wordLength);
        return 3'd4 + {1'b0, wordLength};
    endfunction

    // Index of the final tick in the stop phase; 1.5 stop bits only exist for 5-bit words.
    function automatic logic [4:0] stopTickLast(input logic stopBits, input logic [1:0] wordLength);
        if (!stopBits)
            return 5'(TICKS_PER_BIT - 1);
        else if (wordLength == WL_5)
            return 5'(TICKS_STOP_1P5 - 1);
        return 5'(TICKS_STOP_2 - 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling prescaler: one tick16 pulse every baudDivisor clocks, frozen while the divisor is 0.
module uart_baud_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] baudDivisor,
    output logic        tick16
);

    logic [15:0] count;

    // >= rather than == so a divisor lowered below the running count still reloads promptly.
    assign tick16 = (baudDivisor != 16'd0) && (count >= baudDivisor - 16'd1);

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (baudDivisor == 16'd0)
            count <= count;
        else if (tick16)
            count <= '0;
        else
            count <= count + 16'd1;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: pops the TX FIFO and drives TXD with start/data/parity/stop framing.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
//   IDLE   | line high, waiting for a byte and a nonzero divisor
//   START  | start bit (low)
//   DATA   | 5..8 data bits, LSB first
//   PARITY | parity bit (UART_TX_PARITY_EN builds only)
//   STOP   | 1, 1.5 or 2 stop bits (high)
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        fifoEmpty,
    input  logic [7:0]  fifoData,
    output logic        fifoRe,
    input  logic [15:0] baudDivisor,
    input  logic [1:0]  wordLength,
    input  logic        stopBits,
    input  logic        parityEnable,
    input  logic        parityEven,
    input  logic        stickParity,
    input  logic        breakCtrl,
    output logic        txd,
    output logic        busy,
    output logic        txEmpty
);

    logic [2:0] state, stateNext;
    logic [7:0] shiftReg, shiftNext;
    logic [2:0] bitCnt, bitCntNext;
    logic [4:0] tickCnt, tickCntNext;
    logic [4:0] tickLast;
    logic       tick16, bitEnd, popNow, txdNext;

`ifdef UART_TX_PARITY_EN
    logic parityAcc, parityNext, parityBit;
`else
    logic unusedParityIns;
    assign unusedParityIns = parityEnable ^ parityEven ^ stickParity;
`endif

    uart_baud_gen baudGen (
        .clock       (clock),
        .reset       (reset),
        .clear       (popNow),
        .baudDivisor (baudDivisor),
        .tick16      (tick16)
    );

    assign tickLast = (state == ST_STOP) ? stopTickLast(stopBits, wordLength) : 5'(TICKS_PER_BIT - 1);
    assign bitEnd   = tick16 && (tickCnt == tickLast);
    assign fifoRe   = popNow && reset;
    assign txEmpty  = fifoEmpty && !busy && !fifoRe;

    always_comb begin
        stateNext   = state;
        shiftNext   = shiftReg;
        bitCntNext  = bitCnt;
        tickCntNext = tickCnt;
        popNow      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext  = parityAcc;
`endif
        if (tick16 && state != ST_IDLE)
            tickCntNext = tickCnt + 5'd1;
        case (state)
            ST_IDLE:
                if (!fifoEmpty && baudDivisor != 16'd0)
                    popNow = 1'b1;
            ST_START:
                if (bitEnd) begin
                    stateNext   = ST_DATA;
                    tickCntNext = '0;
                end
            ST_DATA:
                if (bitEnd) begin
                    tickCntNext = '0;
                    shiftNext   = shiftReg >> 1;
                    bitCntNext  = bitCnt + 3'd1;
`ifdef UART_TX_PARITY_EN
                    parityNext  = parityAcc ^ shiftReg[0];
                    if (bitCnt == lastDataBit(wordLength))
                        stateNext = parityEnable ? ST_PARITY : ST_STOP;
`else
                    if (bitCnt == lastDataBit(wordLength))
                        stateNext = ST_STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            ST_PARITY:
                if (bitEnd) begin
                    stateNext   = ST_STOP;
                    tickCntNext = '0;
                end
`endif
            ST_STOP:
                if (bitEnd) begin
                    tickCntNext = '0;
                    if (!fifoEmpty)
                        popNow = 1'b1;
                    else
                        stateNext = ST_IDLE;
                end
            default:
                stateNext = ST_IDLE;
        endcase
        // A pop from IDLE or from the last stop cycle starts a fresh frame.
        if (popNow) begin
            stateNext   = ST_START;
            shiftNext   = fifoData;
            bitCntNext  = '0;
            tickCntNext = '0;
`ifdef UART_TX_PARITY_EN
            parityNext  = 1'b0;
`endif
        end
    end

`ifdef UART_TX_PARITY_EN
    assign parityBit = stickParity ? !parityEven : (parityEven ? parityNext : !parityNext);
`endif

    always_comb begin
        txdNext = 1'b1;
        case (stateNext)
            ST_START:  txdNext = 1'b0;
            ST_DATA:   txdNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txdNext = parityBit;
`endif
            default:   txdNext = 1'b1;
        endcase
        if (breakCtrl)
            txdNext = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            tickCnt  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitCnt   <= bitCntNext;
            tickCnt  <= tickCntNext;
            txd      <= txdNext;
            busy     <= (stateNext != ST_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset)
            parityAcc <= 1'b0;
        else
            parityAcc <= parityNext;
    end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: cycle-accurate TXD frame checks against hand-built bit sequences.
`timescale 1ns/1ps
module tb_uart_tx_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fifoEmpty;
    logic [7:0]  fifoData;
    logic        fifoRe;
    logic [15:0] baudDivisor = 16'd1;
    logic [1:0]  wordLength = 2'd3;
    logic        stopBits = 1'b0;
    logic        parityEnable = 1'b0;
    logic        parityEven = 1'b0;
    logic        stickParity = 1'b0;
    logic        breakCtrl = 1'b0;
    logic        txd, busy, txEmpty;

    logic [7:0] fifoMem [0:15];
    int rdPtr = 0;
    int wrPtr = 0;
    int popCount = 0;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign fifoEmpty = (rdPtr == wrPtr);
    assign fifoData  = fifoMem[4'(rdPtr)];

    always @(posedge clock) begin
        if (fifoRe) begin
            rdPtr    <= rdPtr + 1;
            popCount <= popCount + 1;
        end
    end

    uart_tx_engine dut (
        .clock        (clock),
        .reset        (reset),
        .fifoEmpty    (fifoEmpty),
        .fifoData     (fifoData),
        .fifoRe       (fifoRe),
        .baudDivisor  (baudDivisor),
        .wordLength   (wordLength),
        .stopBits     (stopBits),
        .parityEnable (parityEnable),
        .parityEven   (parityEven),
        .stickParity  (stickParity),
        .breakCtrl    (breakCtrl),
        .txd          (txd),
        .busy         (busy),
        .txEmpty      (txEmpty)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifoMem[4'(wrPtr)] = b;
        wrPtr = wrPtr + 1;
    endtask

    // Returns in the cycle where fifoRe is high (sampled mid-cycle).
    task automatic waitPop(input string tag);
        bit seen;
        seen = 0;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (fifoRe === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clock);
        end
        if (!seen) checkVal({tag, " pop timeout"}, 32'd0, 32'd1);
    endtask

    // Entered at the negedge of the first start-bit cycle; leaves at the negedge of the last stop cycle.
    task automatic runFrame(input string tag, input int div, input logic [11:0] expSeq,
                            input int nSym, input int stopTicks);
        int errs;
        int len;
        logic [11:0] obs;
        logic expBit;
        errs = 0;
        obs  = '0;
        for (int s = 0; s < nSym; s++) begin
            len    = (s == nSym - 1) ? stopTicks * div : 16 * div;
            expBit = expSeq[s];
            for (int c = 0; c < len; c++) begin
                if (s != 0 || c != 0) @(negedge clock);
                if (txd !== expBit || busy !== 1'b1) errs++;
                if (c == len / 2) obs[s] = txd;
            end
        end
        checkVal({tag, " mid-bit txd"}, 32'(obs), 32'(expSeq));
        checkVal({tag, " cycle errors"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int basePops;
        int bad;

        repeat (3) @(negedge clock);
        checkVal("reset txd", 32'(txd), 32'd1);
        checkVal("reset fifoRe", 32'(fifoRe), 32'd0);
        checkVal("reset busy", 32'(busy), 32'd0);
        checkVal("reset txEmpty", 32'(txEmpty), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 8N1, divisor 1, 0x55
        pushByte(8'h55);
        waitPop("t1");
        @(negedge clock);
        runFrame("t1", 1, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 16);
        checkVal("t1 no repop", 32'(fifoRe), 32'd0);
        @(negedge clock);
        checkVal("t1 busy end", 32'(busy), 32'd0);
        checkVal("t1 txEmpty", 32'(txEmpty), 32'd1);
        checkVal("t1 txd idle", 32'(txd), 32'd1);
        checkVal("t1 pops", 32'(popCount), 32'd1);

        // 7E1, divisor 2, back-to-back 0x41 then 0x7F
        baudDivisor  = 16'd2;
        wordLength   = 2'd2;
        parityEnable = 1'b1;
        parityEven   = 1'b1;
        pushByte(8'h41);
        pushByte(8'h7F);
        waitPop("t2a");
        @(negedge clock);
`ifdef UART_TX_PARITY_EN
        runFrame("t2a", 2, {2'b00, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 16);
`else
        runFrame("t2a", 2, {3'b000, 1'b1, 7'h41, 1'b0}, 9, 16);
`endif
        checkVal("t2 back-to-back pop", 32'(fifoRe), 32'd1);
        @(negedge clock);
`ifdef UART_TX_PARITY_EN
        runFrame("t2b", 2, {2'b00, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, 16);
`else
        runFrame("t2b", 2, {3'b000, 1'b1, 7'h7F, 1'b0}, 9, 16);
`endif
        @(negedge clock);
        checkVal("t2 busy end", 32'(busy), 32'd0);
        checkVal("t2 pops", 32'(popCount), 32'd3);
        parityEnable = 1'b0;
        parityEven   = 1'b0;

        // 5 data bits, 1.5 stop bits, 0x1F
        baudDivisor = 16'd1;
        wordLength  = 2'd0;
        stopBits    = 1'b1;
        pushByte(8'h1F);
        waitPop("t3");
        @(negedge clock);
        runFrame("t3", 1, {5'b00000, 1'b1, 5'h1F, 1'b0}, 7, 24);
        @(negedge clock);
        checkVal("t3 busy end", 32'(busy), 32'd0);
        checkVal("t3 txd idle", 32'(txd), 32'd1);
        wordLength = 2'd3;
        stopBits   = 1'b0;

        // Break during a frame of 0xFF
        breakCtrl = 1'b1;
        pushByte(8'hFF);
        waitPop("t4");
        @(negedge clock);
        runFrame("t4", 1, 12'h000, 10, 16);
        @(negedge clock);
        checkVal("t4 busy end", 32'(busy), 32'd0);
        checkVal("t4 txd held low", 32'(txd), 32'd0);
        checkVal("t4 pops", 32'(popCount), 32'd5);
        breakCtrl = 1'b0;
        @(negedge clock);
        checkVal("t4 txd release", 32'(txd), 32'd1);

        // Reset in the middle of DATA
        pushByte(8'hA5);
        pushByte(8'h3C);
        waitPop("t5a");
        repeat (40) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkVal("t5 reset txd", 32'(txd), 32'd1);
        checkVal("t5 reset busy", 32'(busy), 32'd0);
        checkVal("t5 reset fifoRe", 32'(fifoRe), 32'd0);
        @(negedge clock);
        checkVal("t5 reset no pop", 32'(fifoRe), 32'd0);
        reset = 1'b1;
        waitPop("t5b");
        @(negedge clock);
        runFrame("t5b", 1, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 16);
        @(negedge clock);
        checkVal("t5 pops", 32'(popCount), 32'd7);

        // Divisor 0 halts, then divisor 3
        baudDivisor = 16'd0;
        basePops    = popCount;
        pushByte(8'h96);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fifoRe !== 1'b0 || txd !== 1'b1) bad++;
        end
        checkVal("t6 halted errors", 32'(bad), 32'd0);
        checkVal("t6 halted pops", 32'(popCount), 32'(basePops));
        checkVal("t6 txEmpty", 32'(txEmpty), 32'd0);
        baudDivisor = 16'd3;
        waitPop("t6");
        @(negedge clock);
        runFrame("t6", 3, {2'b00, 1'b1, 8'h96, 1'b0}, 10, 16);
        @(negedge clock);
        checkVal("t6 busy end", 32'(busy), 32'd0);
        checkVal("t6 txEmpty end", 32'(txEmpty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
